// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with a shared period and per-channel duty, phase and polarity.
// Config lands in a shadow set and is promoted to the active set only at a safe point.
module pwm_multi_ch #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [N_CH*CNT_W-1:0]   cfg_duty,
  input  logic [N_CH*CNT_W-1:0]   cfg_phase,
  input  logic [N_CH-1:0]         cfg_pol,
  output logic [N_CH-1:0]         pwm_o,
  output logic                    period_end,
  output logic                    cfg_applied
);

  logic [CNT_W-1:0]            per_a, per_s;
  logic [N_CH-1:0][CNT_W-1:0]  duty_a, duty_s;
  logic [N_CH-1:0][CNT_W-1:0]  phase_a, phase_s;
  logic [N_CH-1:0]             pol_a, pol_s;
  logic [N_CH-1:0][CNT_W-1:0]  ch_cnt;
  logic [CNT_W-1:0]            cnt;
  logic                        pending;

  logic             per_zero;
  logic [CNT_W-1:0] per_last;
  logic             boundary;
  logic             apply;
  logic             accept;

  assign per_zero  = (per_a == '0);
  assign per_last  = per_a - 1'b1;
  assign boundary  = en & ~per_zero & (cnt == per_last);
  // Promotion is safe whenever no waveform is being drawn, or at the end of a period.
  assign apply     = pending & (~en | per_zero | boundary);
  assign accept    = cfg_valid & ~pending;
  assign cfg_ready = ~pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_a       <= '0;
      per_s       <= '0;
      duty_a      <= '0;
      duty_s      <= '0;
      phase_a     <= '0;
      phase_s     <= '0;
      pol_a       <= '0;
      pol_s       <= '0;
      ch_cnt      <= '0;
      cnt         <= '0;
      pending     <= 1'b0;
      pwm_o       <= '0;
      period_end  <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      cfg_applied <= apply;
      period_end  <= boundary;
      for (int i = 0; i < N_CH; i++) begin
        pwm_o[i] <= ((ch_cnt[i] < duty_a[i]) & en & ~per_zero) ^ pol_a[i];
      end

      if (accept) begin
        per_s   <= cfg_period;
        duty_s  <= cfg_duty;
        phase_s <= cfg_phase;
        pol_s   <= cfg_pol;
        pending <= 1'b1;
      end

      if (apply) begin
        per_a   <= per_s;
        duty_a  <= duty_s;
        phase_a <= phase_s;
        pol_a   <= pol_s;
        pending <= 1'b0;
        cnt     <= '0;
        // Out-of-range phase starts the channel at zero rather than wrapping modulo P.
        for (int i = 0; i < N_CH; i++) begin
          ch_cnt[i] <= (phase_s[i] < per_s) ? phase_s[i] : '0;
        end
      end else if (en && !per_zero) begin
        cnt <= (cnt == per_last) ? '0 : cnt + 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          ch_cnt[i] <= (ch_cnt[i] == per_last) ? '0 : ch_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
